// File: rtl/huffman_bit_packer_pkg.sv
// Shared types and constants for the Huffman bit packer: table entry layout, FSM state codes,
// accumulator default width. Byte stuffing is selected by HUFF_BYTE_STUFF_EN in the top.
package huffman_bit_packer_pkg;

  localparam int H             = 16;
  localparam int ACC_W_DEFAULT = 40;
  localparam int CODE_W        = 16;

  // code is right-aligned in code[size-1:0]; entries with valid=0 never match
  typedef struct packed {
    logic              valid;
    logic [7:0]        symbol;
    logic [CODE_W-1:0] code;
    logic [4:0]        size;
  } huff_table_entry_t;

  localparam logic [1:0] ST_ACCEPT = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_STUFF  = 2'd2;
  localparam logic [1:0] ST_PAD    = 2'd3;

  function automatic logic [CODE_W-1:0] code_mask(input logic [4:0] n);
    code_mask = (CODE_W'(1) << n) - CODE_W'(1);
  endfunction

endpackage

// File: rtl/huffman_code_lookup.sv
// Reverse table lookup: {run,size} -> codeword, code length, hit. Purely combinational;
// the highest matching table index wins.
module huffman_code_lookup
  import huffman_bit_packer_pkg::*;
(
  input  logic                        i_run_valid,
  input  logic [3:0]                  i_run,
  input  logic [3:0]                  i_size,
  input  huff_table_entry_t [H-1:0]   i_table,
  output logic [CODE_W-1:0]           o_code,
  output logic [4:0]                  o_code_size,
  output logic                        o_hit
);

  always_comb begin
    o_code      = '0;
    o_code_size = '0;
    o_hit       = 1'b0;
    for (int i = 0; i < H; i++) begin
      // lengths outside 1..16 cannot be represented in the accumulator budget
      if (i_run_valid && i_table[i].valid && (i_table[i].symbol == {i_run, i_size}) &&
          (i_table[i].size != 5'd0) && (i_table[i].size <= 5'd16)) begin
        o_hit       = 1'b1;
        o_code      = i_table[i].code & code_mask(i_table[i].size);
        o_code_size = i_table[i].size;
      end
    end
  end

endmodule

// File: rtl/huffman_bit_packer.sv
// JPEG entropy bit packer: symbol -> codeword + amplitude bits -> MSB-first byte stream with
// 1-padding on flush. Defining HUFF_BYTE_STUFF_EN inserts 0x00 after every emitted 0xFF.
module huffman_bit_packer
  import huffman_bit_packer_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEFAULT,
  parameter int AMP_W = 16
)
(
  input  logic                      i_clock,
  input  logic                      i_reset_n,
  input  huff_table_entry_t [H-1:0] i_table,
  input  logic                      i_in_valid,
  output logic                      o_in_ready,
  input  logic [3:0]                i_in_run,
  input  logic [3:0]                i_in_size,
  input  logic [AMP_W-1:0]          i_in_amp,
  input  logic                      i_flush,
  output logic                      o_out_valid,
  input  logic                      i_out_ready,
  output logic [7:0]                o_out_byte,
  output logic                      o_flush_done,
  output logic                      o_err
);

  localparam int CNT_W = $clog2(ACC_W + 1);

  logic [1:0]       r_state;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_count;
  logic             r_flush_pend;
  logic             r_err;
  logic             r_run;

  logic [CODE_W-1:0] w_code;
  logic [4:0]        w_code_size;
  logic              w_hit;
  logic              w_accept;
  logic [AMP_W-1:0]  w_amp_mask;
  logic [ACC_W-1:0]  w_bits;
  logic [CNT_W-1:0]  w_nbits;
  logic [CNT_W-1:0]  w_shift;
  logic [CNT_W-1:0]  w_count_hit;
  logic [CNT_W-1:0]  w_count_drained;
  logic [7:0]        w_top;
  logic              w_flush_any;

  huffman_code_lookup u_lookup (
    .i_run_valid (i_in_valid),
    .i_run       (i_in_run),
    .i_size      (i_in_size),
    .i_table     (i_table),
    .o_code      (w_code),
    .o_code_size (w_code_size),
    .o_hit       (w_hit)
  );

  assign w_accept        = i_in_valid && o_in_ready;
  assign w_amp_mask      = (AMP_W'(1) << i_in_size) - AMP_W'(1);
  // codeword sits above the amplitude, both right-aligned before placement
  assign w_bits          = (ACC_W'(w_code) << i_in_size) | ACC_W'(i_in_amp & w_amp_mask);
  assign w_nbits         = CNT_W'(w_code_size) + CNT_W'(i_in_size);
  assign w_shift         = CNT_W'(ACC_W) - r_count - w_nbits;
  assign w_count_hit     = r_count + w_nbits;
  assign w_count_drained = r_count - CNT_W'(8);
  assign w_top           = r_acc[ACC_W-1 -: 8];
  assign w_flush_any     = r_flush_pend || i_flush;

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_state      <= ST_ACCEPT;
      r_acc        <= '0;
      r_count      <= '0;
      r_flush_pend <= 1'b0;
      r_err        <= 1'b0;
      r_run        <= 1'b0;
    end else begin
      r_run <= 1'b1;
      if (i_flush) r_flush_pend <= 1'b1;
      case (r_state)
        ST_ACCEPT: begin
          if (w_accept) begin
            if (w_hit) begin
              r_acc   <= r_acc | (w_bits << w_shift);
              r_count <= w_count_hit;
              if (w_count_hit >= CNT_W'(8)) r_state <= ST_DRAIN;
              else if (w_flush_any)         r_state <= ST_PAD;
            end else begin
              r_err <= 1'b1;
              if (w_flush_any) r_state <= ST_PAD;
            end
          end else if (w_flush_any && (r_count < CNT_W'(8))) begin
            r_state <= ST_PAD;
          end
        end
        ST_DRAIN: begin
          if (i_out_ready) begin
            r_acc   <= r_acc << 8;
            r_count <= w_count_drained;
`ifdef HUFF_BYTE_STUFF_EN
            if (w_top == 8'hFF) r_state <= ST_STUFF;
            else
`endif
            if (w_count_drained >= CNT_W'(8)) r_state <= ST_DRAIN;
            else if (w_flush_any)             r_state <= ST_PAD;
            else                              r_state <= ST_ACCEPT;
          end
        end
`ifdef HUFF_BYTE_STUFF_EN
        ST_STUFF: begin
          if (i_out_ready) begin
            if (r_count >= CNT_W'(8)) r_state <= ST_DRAIN;
            else if (w_flush_any)     r_state <= ST_PAD;
            else                      r_state <= ST_ACCEPT;
          end
        end
`endif
        ST_PAD: begin
          if (r_count == '0) begin
            r_flush_pend <= i_flush;
            r_state      <= ST_ACCEPT;
          end else begin
            // ones fill the unused tail of the final byte
            r_acc[ACC_W-1 -: 8] <= w_top | (8'hFF >> r_count);
            r_count             <= CNT_W'(8);
            r_state             <= ST_DRAIN;
          end
        end
        default: r_state <= ST_ACCEPT;
      endcase
    end
  end

  assign o_in_ready   = r_run && (r_state == ST_ACCEPT) && (r_count < CNT_W'(8)) && !r_flush_pend;
`ifdef HUFF_BYTE_STUFF_EN
  assign o_out_valid  = (r_state == ST_DRAIN) || (r_state == ST_STUFF);
`else
  assign o_out_valid  = (r_state == ST_DRAIN);
`endif
  assign o_out_byte   = (r_state == ST_DRAIN) ? w_top : 8'h00;
  assign o_flush_done = (r_state == ST_PAD) && (r_count == '0);
  assign o_err        = r_err;

endmodule

// File: tb/tb_huffman_bit_packer.sv
// Directed bench for huffman_bit_packer; expected bytes are hand-computed bit streams.
module tb_huffman_bit_packer;
  import huffman_bit_packer_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                      reset_n;
  huff_table_entry_t [H-1:0] tbl;
  logic                      in_valid;
  logic                      in_ready;
  logic [3:0]                in_run;
  logic [3:0]                in_size;
  logic [15:0]               in_amp;
  logic                      flush;
  logic                      out_valid;
  logic                      out_ready;
  logic [7:0]                out_byte;
  logic                      flush_done;
  logic                      err;

  int n_tests = 0;
  int n_fail  = 0;

  huffman_bit_packer #(.ACC_W(40), .AMP_W(16)) dut (
    .i_clock      (clk),
    .i_reset_n    (reset_n),
    .i_table      (tbl),
    .i_in_valid   (in_valid),
    .o_in_ready   (in_ready),
    .i_in_run     (in_run),
    .i_in_size    (in_size),
    .i_in_amp     (in_amp),
    .i_flush      (flush),
    .o_out_valid  (out_valid),
    .i_out_ready  (out_ready),
    .o_out_byte   (out_byte),
    .o_flush_done (flush_done),
    .o_err        (err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_entry(input int idx, input logic [7:0] sym, input logic [15:0] code,
                           input logic [4:0] size);
    tbl[idx].valid  = 1'b1;
    tbl[idx].symbol = sym;
    tbl[idx].code   = code;
    tbl[idx].size   = size;
  endtask

  task automatic send(input logic [3:0] run, input logic [3:0] size, input logic [15:0] amp);
    bit done;
    done     = 1'b0;
    in_run   = run;
    in_size  = size;
    in_amp   = amp;
    in_valid = 1'b1;
    for (int k = 0; k < 30 && !done; k++) begin
      if (in_ready) done = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    check("send_accepted", 32'(done), 32'd1);
  endtask

  task automatic expect_byte(input string tag, input logic [7:0] exp);
    bit         got;
    logic [7:0] b;
    got       = 1'b0;
    b         = 8'h00;
    out_ready = 1'b1;
    for (int k = 0; k < 30 && !got; k++) begin
      if (out_valid) begin
        got = 1'b1;
        b   = out_byte;
      end
      tick();
    end
    out_ready = 1'b0;
    check({tag, "_seen"}, 32'(got), 32'd1);
    check(tag, 32'(b), 32'(exp));
  endtask

  task automatic expect_flush_done(input string tag);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 30 && !seen; k++) begin
      if (flush_done) seen = 1'b1;
      else tick();
    end
    check(tag, 32'(seen), 32'd1);
    tick();
    check({tag, "_pulse"}, 32'(flush_done), 32'd0);
  endtask

  task automatic expect_idle(input string tag);
    for (int k = 0; k < 3; k++) begin
      check(tag, 32'(out_valid), 32'd0);
      tick();
    end
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_run    = 4'h0;
    in_size   = 4'h0;
    in_amp    = 16'h0;
    flush     = 1'b0;
    out_ready = 1'b0;
    tbl       = '0;
    set_entry(0, 8'h01, 16'h0000, 5'd2);
    set_entry(1, 8'h00, 16'h000A, 5'd4);
    set_entry(2, 8'h23, 16'h0036, 5'd6);
    set_entry(3, 8'hFF, 16'hA5C3, 5'd16);
    tick();
    tick();
    check("rst_in_ready",   32'(in_ready),   32'd0);
    check("rst_out_valid",  32'(out_valid),  32'd0);
    check("rst_out_byte",   32'(out_byte),   32'd0);
    check("rst_flush_done", 32'(flush_done), 32'd0);
    check("rst_err",        32'(err),        32'd0);
    reset_n = 1'b1;
    tick();
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // basic pack: 001 + 1010 + pad 1 -> 0x35
    send(4'd0, 4'd1, 16'h0001);
    send(4'd0, 4'd0, 16'h0000);
    check("basic_no_early_byte", 32'(out_valid), 32'd0);
    do_flush();
    expect_byte("basic_byte", 8'h35);
    expect_flush_done("basic_done");

    // flush on empty accumulator
    do_flush();
    check("empty_flush_done", 32'(flush_done), 32'd1);
    check("empty_flush_nobyte", 32'(out_valid), 32'd0);
    tick();
    check("empty_flush_pulse", 32'(flush_done), 32'd0);

    // higher index overrides EOB with an 8-bit 0xFF code
    set_entry(5, 8'h00, 16'h00FF, 5'd8);
    send(4'd0, 4'd0, 16'h0000);
    expect_byte("stuff_ff", 8'hFF);
`ifdef HUFF_BYTE_STUFF_EN
    expect_byte("stuff_00", 8'h00);
`endif
    expect_idle("stuff_idle");
    tbl[5].valid = 1'b0;

    // backpressure: 110110 101 -> 0xDA, then 1 + 1010 + pad -> 0xD7
    send(4'd2, 4'd3, 16'h0005);
    for (int k = 0; k < 5; k++) begin
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_byte",  32'(out_byte),  32'hDA);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    expect_byte("bp_release", 8'hDA);
    send(4'd0, 4'd0, 16'h0000);
    do_flush();
    expect_byte("bp_tail", 8'hD7);
    expect_flush_done("bp_done");

    // missing symbol (3,5)
    send(4'd3, 4'd5, 16'h001F);
    check("miss_err", 32'(err), 32'd1);
    check("miss_in_ready", 32'(in_ready), 32'd1);
    expect_idle("miss_idle");

    // max-length: 7 residual + 16 code + 15 amp = 38 bits
    send(4'd0, 4'd1, 16'h0001);
    send(4'd0, 4'd0, 16'h0000);
    send(4'd15, 4'd15, 16'h7FFF);
    expect_byte("max_b0", 8'h35);
    expect_byte("max_b1", 8'h4B);
    expect_byte("max_b2", 8'h87);
    expect_byte("max_b3", 8'hFF);
`ifdef HUFF_BYTE_STUFF_EN
    expect_byte("max_b3_stuff", 8'h00);
`endif
    check("max_residual_idle", 32'(out_valid), 32'd0);
    check("max_residual_ready", 32'(in_ready), 32'd1);
    check("max_err_sticky", 32'(err), 32'd1);
    do_flush();
    expect_byte("max_pad", 8'hFF);
`ifdef HUFF_BYTE_STUFF_EN
    expect_byte("max_pad_stuff", 8'h00);
`endif
    expect_flush_done("max_done");

    // reset while draining
    send(4'd2, 4'd3, 16'h0005);
    check("mid_drain_valid", 32'(out_valid), 32'd1);
    reset_n = 1'b0;
    tick();
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_err",       32'(err),       32'd0);
    check("mid_rst_in_ready",  32'(in_ready),  32'd0);
    reset_n = 1'b1;
    tick();
    check("mid_rst_ready_back", 32'(in_ready), 32'd1);
    send(4'd0, 4'd0, 16'h0000);
    do_flush();
    expect_byte("mid_rst_fresh", 8'hAF);
    expect_flush_done("mid_rst_done");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
